// File: rtl/sb_tx_arbiter.sv
// Round-robin arbiter that feeds one sideband message at a time into SB_TX.
// Optional ack timeout is compiled in with `define SB_ARB_TIMEOUT_EN.
module sb_tx_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int DATA_W      = 64,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                      clk_100MHz,
  input  logic                      reset_n,
  input  logic                      enable_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] data_i,
  output logic [DATA_W-1:0]         tx_data_o,
  output logic                      tx_valid_o,
  input  logic                      tx_ack_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic                      busy_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_e;

  state_e state_q, state_d;

  logic [IDX_W-1:0]  last_gnt, win_idx, pick_idx, cand;
  logic              pick_valid;
  logic [DATA_W-1:0] pick_data;
  logic              grant_fire, ack_fire, tout_fire;

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last_gnt) + i) % NUM_REQ);
      if (!pick_valid && req_i[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    pick_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_idx == IDX_W'(k)) pick_data = data_i[k*DATA_W +: DATA_W];
    end
  end

  assign grant_fire = (state_q == IDLE) && enable_i && pick_valid;
  assign ack_fire   = (state_q == SEND) && tx_ack_i;

`ifdef SB_ARB_TIMEOUT_EN
  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  logic [CNT_W-1:0] ack_cnt;
  logic             err_q;

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      ack_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= tout_fire;
      if (state_q != SEND) ack_cnt <= '0;
      else if (!tx_ack_i)  ack_cnt <= ack_cnt + CNT_W'(1);
    end
  end

  assign tout_fire = (state_q == SEND) && !tx_ack_i &&
                     (ack_cnt == CNT_W'(ACK_TIMEOUT - 1));
  assign err_o     = err_q;
`else
  assign tout_fire = 1'b0;
  assign err_o     = 1'b0;
`endif

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // RELEASE waits for a level ack to drop so it cannot complete a second message.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_fire) state_d = SEND;
      SEND: begin
        if (ack_fire)       state_d = RELEASE;
        else if (tout_fire) state_d = IDLE;
      end
      RELEASE: if (!tx_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != IDLE);
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      tx_data_o  <= '0;
      tx_valid_o <= 1'b0;
      win_idx    <= '0;
      last_gnt   <= IDX_W'(NUM_REQ - 1);
      gnt_o      <= '0;
      done_o     <= 1'b0;
    end else begin
      done_o <= ack_fire;
      gnt_o  <= '0;
      if (grant_fire) begin
        tx_data_o  <= pick_data;
        tx_valid_o <= 1'b1;
        win_idx    <= pick_idx;
      end
      if (ack_fire || tout_fire) begin
        tx_valid_o <= 1'b0;
        gnt_o      <= NUM_REQ'(1) << win_idx;
        last_gnt   <= win_idx;
      end
    end
  end

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Directed bench for sb_tx_arbiter; covers both builds of SB_ARB_TIMEOUT_EN.
module tb_sb_tx_arbiter;

  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 64;

  localparam logic [63:0] D0 = 64'hF0AABBCC1122330F;
  localparam logic [63:0] D1 = 64'h1234567890ABCDEF;
  localparam logic [63:0] D2 = 64'hFEEDBEEFCAFEBABE;

  logic                      clk_100MHz = 1'b0;
  logic                      reset_n;
  logic                      enable_i;
  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ*DATA_W-1:0] data_i;
  logic [DATA_W-1:0]         tx_data_o;
  logic                      tx_valid_o;
  logic                      tx_ack_i;
  logic [NUM_REQ-1:0]        gnt_o;
  logic                      done_o;
  logic                      err_o;
  logic                      busy_o;

  int checks = 0;
  int errors = 0;
  int done_count;
  logic [63:0] data_tbl [3];

  sb_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_W(DATA_W),
    .ACK_TIMEOUT(16)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .reset_n(reset_n),
    .enable_i(enable_i),
    .req_i(req_i),
    .data_i(data_i),
    .tx_data_o(tx_data_o),
    .tx_valid_o(tx_valid_o),
    .tx_ack_i(tx_ack_i),
    .gnt_o(gnt_o),
    .done_o(done_o),
    .err_o(err_o),
    .busy_o(busy_o)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] req, input logic ack, input logic en);
    req_i    = req;
    tx_ack_i = ack;
    enable_i = en;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    applyStimulus(3'b000, 1'b0, 1'b1);
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    data_i      = {D2, D1, D0};
    data_tbl[0] = D0;
    data_tbl[1] = D1;
    data_tbl[2] = D2;

    // Reset state
    doReset();
    checkOutput("rst_valid", 64'(tx_valid_o), 64'd0);
    checkOutput("rst_data",  tx_data_o,       64'd0);
    checkOutput("rst_gnt",   64'(gnt_o),      64'd0);
    checkOutput("rst_done",  64'(done_o),     64'd0);
    checkOutput("rst_err",   64'(err_o),      64'd0);
    checkOutput("rst_busy",  64'(busy_o),     64'd0);

    // Single requester, ack three cycles after valid
    $display("[TB] single request");
    applyStimulus(3'b001, 1'b0, 1'b1);
    tick();
    checkOutput("single_valid", 64'(tx_valid_o), 64'd1);
    checkOutput("single_data",  tx_data_o,       D0);
    checkOutput("single_busy",  64'(busy_o),     64'd1);
    tick();
    tick();
    checkOutput("single_hold", 64'(tx_valid_o), 64'd1);
    applyStimulus(3'b001, 1'b1, 1'b1);
    tick();
    checkOutput("single_done",   64'(done_o),     64'd1);
    checkOutput("single_gnt",    64'(gnt_o),      64'b001);
    checkOutput("single_vclear", 64'(tx_valid_o), 64'd0);
    applyStimulus(3'b000, 1'b0, 1'b1);
    tick();
    checkOutput("single_gnt0",  64'(gnt_o),  64'd0);
    checkOutput("single_done0", 64'(done_o), 64'd0);
    checkOutput("single_idle",  64'(busy_o), 64'd0);

    // All requesters held: rotation 0,1,2
    $display("[TB] round robin");
    doReset();
    applyStimulus(3'b111, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("rr_valid", 64'(tx_valid_o), 64'd1);
      checkOutput("rr_data",  tx_data_o,       data_tbl[k]);
      tick();
      applyStimulus(3'b111, 1'b1, 1'b1);
      tick();
      checkOutput("rr_done", 64'(done_o), 64'd1);
      checkOutput("rr_gnt",  64'(gnt_o),  64'(3'b001 << k));
      applyStimulus(3'b111, 1'b0, 1'b1);
      tick();
      checkOutput("rr_idle", 64'(busy_o), 64'd0);
      checkOutput("rr_gnt0", 64'(gnt_o),  64'd0);
    end
    applyStimulus(3'b000, 1'b0, 1'b1);
    tick();

    // Level ack held five cycles counts once
    $display("[TB] held ack");
    doReset();
    applyStimulus(3'b001, 1'b0, 1'b1);
    tick();
    checkOutput("hold_valid", 64'(tx_valid_o), 64'd1);
    applyStimulus(3'b010, 1'b1, 1'b1);
    done_count = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (done_o) done_count++;
      checkOutput("hold_novalid", 64'(tx_valid_o), 64'd0);
    end
    checkOutput("hold_done_count", 64'(done_count), 64'd1);
    applyStimulus(3'b010, 1'b0, 1'b1);
    tick();
    checkOutput("hold_release_valid", 64'(tx_valid_o), 64'd0);
    checkOutput("hold_release_busy",  64'(busy_o),     64'd0);
    tick();
    checkOutput("hold_next_valid", 64'(tx_valid_o), 64'd1);
    checkOutput("hold_next_data",  tx_data_o,       D1);
    applyStimulus(3'b010, 1'b1, 1'b1);
    tick();
    checkOutput("hold_next_gnt", 64'(gnt_o), 64'b010);
    applyStimulus(3'b000, 1'b0, 1'b1);
    tick();

    // enable_i dropped mid-transfer
    $display("[TB] enable drop");
    doReset();
    applyStimulus(3'b100, 1'b0, 1'b1);
    tick();
    checkOutput("en_valid", 64'(tx_valid_o), 64'd1);
    checkOutput("en_data",  tx_data_o,       D2);
    applyStimulus(3'b100, 1'b0, 1'b0);
    tick();
    checkOutput("en_hold", 64'(tx_valid_o), 64'd1);
    applyStimulus(3'b100, 1'b1, 1'b0);
    tick();
    checkOutput("en_done", 64'(done_o), 64'd1);
    checkOutput("en_gnt",  64'(gnt_o),  64'b100);
    applyStimulus(3'b100, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput("en_blocked", 64'(tx_valid_o), 64'd0);
    end
    applyStimulus(3'b100, 1'b0, 1'b1);
    tick();
    checkOutput("en_resume_valid", 64'(tx_valid_o), 64'd1);
    checkOutput("en_resume_data",  tx_data_o,       D2);
    applyStimulus(3'b000, 1'b1, 1'b1);
    tick();
    applyStimulus(3'b000, 1'b0, 1'b1);
    tick();

    // Asynchronous reset during SEND
    $display("[TB] reset mid-transfer");
    doReset();
    applyStimulus(3'b001, 1'b0, 1'b1);
    tick();
    checkOutput("ar_valid_pre", 64'(tx_valid_o), 64'd1);
    reset_n = 1'b0;
    #2;
    checkOutput("ar_valid", 64'(tx_valid_o), 64'd0);
    checkOutput("ar_data",  tx_data_o,       64'd0);
    checkOutput("ar_busy",  64'(busy_o),     64'd0);
    checkOutput("ar_done",  64'(done_o),     64'd0);
    checkOutput("ar_err",   64'(err_o),      64'd0);
    checkOutput("ar_gnt",   64'(gnt_o),      64'd0);
    #2;
    reset_n = 1'b1;
    applyStimulus(3'b110, 1'b0, 1'b1);
    tick();
    checkOutput("ar_win_valid", 64'(tx_valid_o), 64'd1);
    checkOutput("ar_win_data",  tx_data_o,       D1);
    applyStimulus(3'b110, 1'b1, 1'b1);
    tick();
    checkOutput("ar_win_gnt", 64'(gnt_o), 64'b010);
    applyStimulus(3'b000, 1'b0, 1'b1);
    tick();

    // Ack never arrives
    $display("[TB] missing ack");
    doReset();
    applyStimulus(3'b001, 1'b0, 1'b1);
    tick();
    checkOutput("to_valid", 64'(tx_valid_o), 64'd1);
    applyStimulus(3'b000, 1'b0, 1'b1);
`ifdef SB_ARB_TIMEOUT_EN
    for (int c = 1; c < 16; c++) begin
      tick();
      checkOutput("to_wait_err",   64'(err_o),      64'd0);
      checkOutput("to_wait_valid", 64'(tx_valid_o), 64'd1);
    end
    tick();
    checkOutput("to_err",   64'(err_o),      64'd1);
    checkOutput("to_gnt",   64'(gnt_o),      64'b001);
    checkOutput("to_done",  64'(done_o),     64'd0);
    checkOutput("to_valid", 64'(tx_valid_o), 64'd0);
    checkOutput("to_idle",  64'(busy_o),     64'd0);
    tick();
    checkOutput("to_err_pulse", 64'(err_o), 64'd0);
`else
    for (int c = 0; c < 24; c++) begin
      tick();
      checkOutput("noto_valid", 64'(tx_valid_o), 64'd1);
      checkOutput("noto_err",   64'(err_o),      64'd0);
    end
    checkOutput("noto_busy", 64'(busy_o), 64'd1);
    checkOutput("noto_data", tx_data_o,   D0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
